conv_3_3_sched: RTL

Sequencer that slides a 3x3 window over an IMG_W x IMG_H image held in a single-port pixel memory and drives one conv_3_3 engine. Per output position it reads 9 pixels, packs them into PATCH, holds KERNEL, waits for the engine and emits RESULT with (x, y) tags on a valid/ready stream. It sits between the pixel buffer and the downstream result sink and is the only owner of the conv_3_3 inputs.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_win_addr.sv | 25 ++
 rtl/conv_3_3_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution sequencer.
// The window element k = r*3 + c sits with k=0 at the MSB of PATCH/KERNEL.
package conv_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 64;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAST,
        CONV,
        OUT,
        DONE
    } state_t;

    // LSB position of window element k in a 9-element packed vector
    function automatic int elem_lsb(input int k, input int dw);
        return (8 - k) * dw;
    endfunction

endpackage

// File: rtl/conv_win_addr.sv
// Window element address: (x, y, k) -> (y+r)*IMG_W + x + c, with k = r*3 + c.
module conv_win_addr #(
    parameter int IMG_W  = 8,
    parameter int ADDR_W = 6
) (
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [3:0]        k,
    output logic [ADDR_W-1:0] addr
);

    logic [3:0] r;
    logic [3:0] c;

    always_comb begin
        r = 4'd0;
        if (k >= 4'd6)
            r = 4'd2;
        else if (k >= 4'd3)
            r = 4'd1;
        c = k - r * 4'd3;
        addr = (ADDR_W'(y) + ADDR_W'(r)) * ADDR_W'(IMG_W) + ADDR_W'(x) + ADDR_W'(c);
    end

endmodule

// File: rtl/conv_3_3_sched.sv
// Slides a 3x3 window over a row-major pixel memory, feeds one conv_3_3 engine
// and streams each result out with its (x, y) position.
module conv_3_3_sched #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int DATA_W   = conv_pkg::DATA_W,
    parameter int ACC_W    = conv_pkg::ACC_W,
    parameter int CONV_LAT = 1,
    parameter int ADDR_W   = 6
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                start,
    input  logic [9*DATA_W-1:0] kernel_in,
    input  logic                kernel_load,
    output logic                pix_rd,
    output logic [ADDR_W-1:0]   pix_addr,
    input  logic [DATA_W-1:0]   pix_data,
    output logic [9*DATA_W-1:0] PATCH,
    output logic [9*DATA_W-1:0] KERNEL,
    input  logic [ACC_W-1:0]    RESULT,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    res_data,
    output logic [7:0]          res_x,
    output logic [7:0]          res_y,
    output logic                busy,
    output logic                done
);

    import conv_pkg::*;

    localparam int LW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

    state_t            state;
    state_t            nxt;
    logic [7:0]        x;
    logic [7:0]        y;
    logic [3:0]        k;
    logic [LW-1:0]     lat;
    logic [ADDR_W-1:0] win_addr;

    wire last_col = (x == 8'(IMG_W - 3));
    wire last_row = (y == 8'(IMG_H - 3));
    wire conv_end = (lat == LW'(CONV_LAT - 1));

    conv_win_addr #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .x    (x),
        .y    (y),
        .k    (k),
        .addr (win_addr)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (start) nxt = FETCH;
            FETCH: if (k == 4'd8) nxt = LAST;
            LAST:  nxt = CONV;
            CONV:  if (conv_end) nxt = OUT;
            OUT:   if (res_ready) nxt = (last_col && last_row) ? DONE : FETCH;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            k        <= '0;
            lat      <= '0;
            PATCH    <= '0;
            KERNEL   <= '0;
            res_data <= '0;
            res_x    <= '0;
            res_y    <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    // kernel load and start in the same cycle: the frame sees the new kernel
                    if (kernel_load)
                        KERNEL <= kernel_in;
                    if (start) begin
                        x <= '0;
                        y <= '0;
                        k <= '0;
                    end
                end
                FETCH: begin
                    // read data lags the strobe by one cycle, so it lands in element k-1
                    if (k != 4'd0)
                        PATCH[elem_lsb(int'(k) - 1, DATA_W) +: DATA_W] <= pix_data;
                    k <= k + 4'd1;
                end
                LAST: begin
                    PATCH[elem_lsb(8, DATA_W) +: DATA_W] <= pix_data;
                    k   <= '0;
                    lat <= '0;
                end
                CONV: begin
                    lat <= lat + LW'(1);
                    if (conv_end) begin
                        res_data <= RESULT;
                        res_x    <= x;
                        res_y    <= y;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        if (last_col) begin
                            if (!last_row) begin
                                x <= '0;
                                y <= y + 8'd1;
                            end
                        end else begin
                            x <= x + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_rd    = (state == FETCH);
    assign pix_addr  = pix_rd ? win_addr : '0;
    assign res_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
